// File: rtl/fetch_pkg.sv
// Shared widths, constants and the prefetch queue entry layout for the fetch stage.
package fetch_pkg;

  localparam int IW    = 19;
  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam logic [IW-1:0] NOP      = '0;
  localparam logic [AW-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched instructions with their PCs.
// The head is read combinationally so decode sees it in the same cycle it becomes valid.
module fetch_queue #(
  parameter int W     = 31,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign do_push   = push && (cnt != CW'(DEPTH));
  assign do_pop    = pop && (cnt != '0);
  assign head_data = mem[rd_ptr];
  assign count     = cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited sequential requests,
// buffers responses for decode and discards everything in flight on a branch redirect.
module if_prefetch_unit
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          id_ready,
  output logic          id_valid,
  output logic [IW-1:0] id_instr,
  output logic [AW-1:0] id_pc
);

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] resp_pc;
  logic [AW-1:0] id_pc_hold;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          rsp;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // Queued plus in-flight entries never exceed DEPTH, so the queue cannot overflow.
  assign credit_used = {1'b0, outstanding} + {1'b0, q_count};
  assign imem_req    = reset && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign issue       = imem_req && imem_gnt;

  // A response with nothing outstanding belongs to a request from before reset.
  assign rsp              = imem_rvalid && (outstanding != '0);
  assign outstanding_next = outstanding + CW'(issue) - CW'(rsp);

  assign push       = rsp && (drop_cnt == '0) && !redirect;
  assign id_valid   = (q_count != '0);
  assign pop        = id_valid && id_ready && !redirect;
  assign push_entry = '{instr: imem_rdata, pc: resp_pc};

  assign id_instr = id_valid ? head_entry.instr : NOP;
  assign id_pc    = id_valid ? head_entry.pc : id_pc_hold;

  fetch_queue #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      id_pc_hold  <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (id_valid)
        id_pc_hold <= head_entry.pc;
      if (redirect) begin
        // Recomputed on every redirect so back-to-back redirects never double count.
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= outstanding_next;
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + AW'(1);
        if (rsp) begin
          if (drop_cnt != '0)
            drop_cnt <= drop_cnt - CW'(1);
          else
            resp_pc <= resp_pc + AW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with a pipelined in-order memory model
// whose response data is the request address.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [18:0] imem_rdata;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [18:0] id_instr;
  logic [11:0] id_pc;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 1;
  int          cyc   = 0;
  logic [11:0] nxt;
  int          due_q[$];
  logic [11:0] adr_q[$];

  if_prefetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  always #5 clk = ~clk;

  // Memory: accepts on req&&gnt, answers 'lat' cycles later in order with {7'b0, addr}.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        due_q.push_back(cyc + lat);
        adr_q.push_back(imem_addr);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = {7'b0, adr_q[0]};
        void'(due_q.pop_front());
        void'(adr_q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Checks n delivered instructions starting at pc 'start'; contig demands one per cycle.
  task automatic expect_stream(input string tag, input logic [11:0] start, input int n,
                               input bit contig);
    int w;
    nxt = start;
    for (int i = 0; i < n; i++) begin
      w = 0;
      @(negedge clk);
      if (!(contig && i > 0))
        while (!id_valid && w < 40) begin
          @(negedge clk);
          w++;
        end
      chk({tag, "_valid"}, 32'(id_valid), 32'd1);
      chk({tag, "_pc"}, 32'(id_pc), 32'(nxt));
      chk({tag, "_instr"}, 32'(id_instr), {20'b0, nxt});
      $display("%s: id_pc=0x%03h id_instr=0x%05h", tag, id_pc, id_instr);
      nxt = nxt + 12'd1;
    end
  endtask

  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b1;
    imem_gnt    = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", 32'(id_instr), 32'd0);
    chk("rst_pc", 32'(id_pc), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // Sequential fetch, 1-cycle memory, one instruction per cycle
    drv_edge();
    reset = 1'b1;
    expect_stream("seq", 12'h000, 8, 1'b1);

    // Backpressure: queue fills to DEPTH and requests stop
    drv_edge();
    id_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(id_valid), 32'd1);
    chk("bp_pc", 32'(id_pc), 32'(nxt));
    chk("bp_count", 32'(dut.q_count), 32'd4);
    $display("bp: held id_pc=0x%03h req=%0b", id_pc, imem_req);
    drv_edge();
    id_ready = 1'b1;
    expect_stream("bp", nxt, 8, 1'b1);

    // Drain, then 3-cycle memory with two requests in flight at the redirect
    drv_edge();
    imem_gnt = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    lat      = 3;
    imem_gnt = 1'b1;
    drv_edge();
    drv_edge();
    redirect    = 1'b1;
    redirect_pc = 12'h100;
    @(negedge clk);
    chk("rd_req", 32'(imem_req), 32'd0);
    drv_edge();
    redirect = 1'b0;
    expect_stream("rd", 12'h100, 4, 1'b0);

    // Redirect to the top of the address space wraps to 0
    drv_edge();
    redirect    = 1'b1;
    redirect_pc = 12'hFFF;
    drv_edge();
    redirect = 1'b0;
    expect_stream("wrap", 12'hFFF, 4, 1'b0);

    // Asynchronous reset with three requests in flight
    drv_edge();
    imem_gnt = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    imem_gnt = 1'b1;
    drv_edge();
    drv_edge();
    drv_edge();
    reset = 1'b0;
    @(negedge clk);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_instr", 32'(id_instr), 32'd0);
    chk("arst_pc", 32'(id_pc), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    $display("arst: req=%0b valid=%0b addr=0x%03h", imem_req, id_valid, imem_addr);
    drv_edge();
    drv_edge();
    reset = 1'b1;
    expect_stream("rst", 12'h000, 3, 1'b0);

    // Back-to-back redirects: only the second target is delivered
    drv_edge();
    redirect    = 1'b1;
    redirect_pc = 12'h040;
    @(negedge clk);
    chk("dbl1_req", 32'(imem_req), 32'd0);
    drv_edge();
    redirect_pc = 12'h080;
    @(negedge clk);
    chk("dbl2_req", 32'(imem_req), 32'd0);
    drv_edge();
    redirect = 1'b0;
    expect_stream("dbl", 12'h080, 5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Instruction fetch stage directly upstream of the processor's IF/ID register. It owns the fetch PC and issues sequential requests to a pipelined, in-order instruction memory. Returned 19-bit instructions are buffered in a small prefetch queue and handed to decode with a valid/ready handshake. Branch redirects from the controller discard all queued and in-flight instructions.

Parameters:
IW, 19, instruction width
AW, 12, instruction address width (word-addressed PC)
DEPTH, 4, prefetch queue entries; also the credit limit on queued plus outstanding requests
CW, $clog2(DEPTH)+1, width of the count, outstanding and drop counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = in reset)
imem_req  out  1  fetch request valid
imem_addr  out  AW  fetch address (= fetch_pc)
imem_gnt  in  1  memory accepts the request this cycle
imem_rvalid  in  1  response valid; responses return in request order
imem_rdata  in  IW  response instruction
redirect  in  1  branch taken (do_branch); one-cycle pulse
redirect_pc  in  AW  branch target
id_ready  in  1  decode can accept (inverse of IF_ID_loadbar)
id_valid  out  1  queue head valid
id_instr  out  IW  queue head instruction
id_pc  out  AW  PC of the queue head

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=0, queue empty, outstanding=0, drop_cnt=0.
  - imem_req=0, id_valid=0, id_instr=NOP (19'b0), id_pc=0.
- Issue rule:
  - imem_req = !redirect && (outstanding + count < DEPTH).
  - On req&&gnt: fetch_pc <= fetch_pc+1, wrapping modulo 2^AW; outstanding increments.
- Response rule, on imem_rvalid:
  - outstanding decrements.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise push {imem_rdata, pc} into the queue. The pc comes from a parallel resp_pc counter that tracks the address of the next non-dropped response.
  - The credit rule guarantees no overflow. rvalid with outstanding==0 is ignored.
- Output:
  - id_valid = queue not empty; id_instr and id_pc are driven from the head.
  - When the queue is empty, id_instr=NOP and id_pc holds its last value.
  - Pop on id_valid && id_ready.
- Simultaneous events: push and pop in the same cycle leave count unchanged. Issue and response in the same cycle leave outstanding unchanged.
- Redirect (has priority over everything):
  - At the next edge: queue flushed (count=0) and fetch_pc <= redirect_pc.
  - resp_pc <= redirect_pc.
  - drop_cnt <= outstanding_next, so every request still in flight gets dropped.
  - No request is issued in the redirect cycle. Any pop in that cycle is void.
  - A response arriving in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins. drop_cnt is recomputed from outstanding each time, so there is no double counting.
- First post-redirect instruction: id_valid rises no earlier than one memory latency plus one cycle after the redirect.
- Reset mid-operation: all state clears immediately. Responses to pre-reset requests that arrive later are ignored because outstanding==0.

Decomposition:
- fetch_pkg holds IW, AW, the NOP constant (19'b0) and RESET_PC (0).
- One sub-module: fetch_queue, a synchronous FIFO (DEPTH x (IW+AW)) with push, pop, flush and count outputs.
- Credit and drop counters stay in if_prefetch_unit.

Test Plan:
- Memory with gnt=1 and 1-cycle latency, rdata = {7'b0, addr}, id_ready=1 -> after reset release, id_pc = 0,1,2,… one per cycle; id_instr equals the address in its low bits.
- id_ready=0 for 10 cycles -> count reaches 4 and imem_req falls with outstanding+count=4. After release, no loss: id_pc continues sequentially.
- 3-cycle-latency memory, redirect to 0x100 with 2 requests outstanding -> the next 2 rvalid are discarded; the first id_valid carries id_pc=0x100.
- Redirect to 0xFFF -> id_pc sequence 0xFFF then 0x000 (wrap).
- reset=0 while 3 requests are in flight -> id_valid=0 and imem_req=0 immediately. Late rvalids are ignored. After release the first id_pc=0.
- redirect on two consecutive cycles (targets 0x040, then 0x080) -> only 0x080, 0x081… are delivered; nothing from 0x040 appears.
